// File: rtl/encoder4x2_queue.sv
// Registered 4-to-2 encoder with sticky pending bits and valid/ready output.
// Fixed (lowest index) or round-robin priority picks the next index to emit.
module encoder4x2_queue #(
   parameter bit RR_MODE = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       out_ready,
   output logic       out_valid,
   output logic       A,
   output logic       B,
   output logic [3:0] pending,
   output logic       overflow,
   output logic       idle
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t     state_q, state_d;
   logic [3:0] p_q, p_d;
   logic [1:0] code_q, code_d;
   logic [1:0] last_q, last_d;
   logic       ovf_q, ovf_d;

   logic       load;
   logic [3:0] load_mask;
   logic [1:0] start;
   logic [1:0] idx;
   logic [1:0] k;
   logic       found;

   // Fixed priority is a scan that always starts after index 3.
   always_comb begin
      start = RR_MODE ? last_q : 2'b11;
      k     = 2'b00;
      idx   = 2'b00;
      found = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         idx = start + 2'(i);
         if (!found && p_q[idx]) begin
            k     = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      code_d    = code_q;
      last_d    = last_q;
      load      = 1'b0;
      load_mask = 4'b0000;
      unique case (state_q)
         EMPTY: begin
            if (p_q != 4'b0000) load = 1'b1;
         end
         FULL: begin
            if (out_ready) begin
               if (p_q != 4'b0000) load = 1'b1;
               else state_d = EMPTY;
            end
         end
      endcase
      if (load) begin
         state_d   = FULL;
         code_d    = k;
         last_d    = k;
         load_mask = 4'b0001 << k;
      end
      p_d   = (p_q & ~load_mask) | req;
      ovf_d = |(req & p_q & ~load_mask);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         p_q     <= 4'b0000;
         code_q  <= 2'b00;
         last_q  <= 2'b11;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         code_q  <= code_d;
         last_q  <= last_d;
         ovf_q   <= ovf_d;
      end
   end

   assign out_valid = (state_q == FULL);
   assign A         = code_q[1];
   assign B         = code_q[0];
   assign pending   = p_q;
   assign overflow  = ovf_q;
   assign idle      = (p_q == 4'b0000) && (state_q == EMPTY);

endmodule

// File: tb/tb_encoder4x2_queue.sv
// Bench for encoder4x2_queue: one fixed-priority and one round-robin
// instance share stimulus and are checked against a set-based model.
module tb_encoder4x2_queue;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] req = 4'b0000;
   logic       out_ready = 1'b0;

   logic [1:0] val, a, b, ovf, idl;
   logic [3:0] pend [2];

   encoder4x2_queue #(.RR_MODE(1'b0)) dut0 (
      .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
      .out_valid(val[0]), .A(a[0]), .B(b[0]),
      .pending(pend[0]), .overflow(ovf[0]), .idle(idl[0])
   );

   encoder4x2_queue #(.RR_MODE(1'b1)) dut1 (
      .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
      .out_valid(val[1]), .A(a[1]), .B(b[1]),
      .pending(pend[1]), .overflow(ovf[1]), .idle(idl[1])
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int got0[$];
   int got1[$];

   int mp[2], mv[2], mc[2], ml[2], mo[2];
   bit live = 1'b0;

   task automatic chk(string nm, int m, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got %0h want %0h", nm, m, act, exp);
      end
   endtask

   function automatic int pick(int m);
      int i;
      if (m == 0) begin
         for (int j = 0; j < 4; j++)
            if (((mp[0] >> j) & 1) == 1) return j;
      end else begin
         for (int j = 1; j <= 4; j++) begin
            i = (ml[1] + j) % 4;
            if (((mp[1] >> i) & 1) == 1) return i;
         end
      end
      return 0;
   endfunction

   // Model: a set of pending indices plus one output slot.
   always @(posedge clk) begin
      int  mask, k;
      bit  fire;
      for (int m = 0; m < 2; m++) begin
         if (rst) begin
            mp[m] = 0; mv[m] = 0; mc[m] = 0; ml[m] = 3; mo[m] = 0;
         end else begin
            mask = 0;
            fire = (mv[m] == 1) && out_ready;
            if ((mv[m] == 0 || fire) && mp[m] != 0) begin
               k = pick(m);
               mc[m] = k; mv[m] = 1; ml[m] = k; mask = 1 << k;
            end else if (fire) begin
               mv[m] = 0;
            end
            mo[m] = ((int'(req) & mp[m] & ~mask) != 0) ? 1 : 0;
            mp[m] = (mp[m] & ~mask) | int'(req);
         end
      end
      if (rst) live = 1'b1;
   end

   always @(negedge clk) begin
      if (live) begin
         for (int m = 0; m < 2; m++) begin
            chk("valid", m, 8'(val[m]), 8'(mv[m]));
            chk("code", m, 8'({a[m], b[m]}), 8'(mc[m]));
            chk("pending", m, 8'(pend[m]), 8'(mp[m]));
            chk("overflow", m, 8'(ovf[m]), 8'(mo[m]));
            chk("idle", m, 8'(idl[m]), 8'((mp[m] == 0 && mv[m] == 0) ? 1 : 0));
         end
         if (!rst && out_ready) begin
            if (val[0]) got0.push_back(int'({a[0], b[0]}));
            if (val[1]) got1.push_back(int'({a[1], b[1]}));
         end
      end
   end

   task automatic step(input logic [3:0] r, input logic rd);
      req = r;
      out_ready = rd;
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      got0.delete();
      got1.delete();
   endtask

   task automatic codes(string nm, int n, int e0[4], int e1[4]);
      int q[$];
      for (int m = 0; m < 2; m++) begin
         q = (m == 0) ? got0 : got1;
         chk({nm, " count"}, m, 8'(q.size()), 8'(n));
         for (int i = 0; i < n && i < q.size(); i++)
            chk({nm, " seq"}, m, 8'(q[i]), 8'(m == 0 ? e0[i] : e1[i]));
      end
   endtask

   task automatic lit(string nm, logic [1:0] v, logic [1:0] c,
                      logic [3:0] p, logic o);
      for (int m = 0; m < 2; m++) begin
         chk({nm, " valid"}, m, 8'(val[m]), 8'(v));
         chk({nm, " code"}, m, 8'({a[m], b[m]}), 8'(c));
         chk({nm, " pending"}, m, 8'(pend[m]), 8'(p));
         chk({nm, " overflow"}, m, 8'(ovf[m]), 8'(o));
      end
   endtask

   initial begin
      rst = 1'b1;
      step(4'hF, 1'b1);
      step(4'hF, 1'b1);
      rst = 1'b0;
      step(4'h0, 1'b0);
      lit("reset", 2'd0, 2'd0, 4'h0, 1'b0);
      for (int m = 0; m < 2; m++) chk("reset idle", m, 8'(idl[m]), 8'd1);

      clr();
      step(4'b0100, 1'b1);
      lit("single load", 2'd0, 2'd0, 4'b0100, 1'b0);
      step(4'b0000, 1'b1);
      lit("single emit", 2'd1, 2'd2, 4'b0000, 1'b0);
      step(4'b0000, 1'b1);
      for (int m = 0; m < 2; m++) chk("single idle", m, 8'(idl[m]), 8'd1);
      step(4'b0000, 1'b1);
      codes("single", 1, '{2, 0, 0, 0}, '{2, 0, 0, 0});

      clr();
      step(4'b1011, 1'b1);
      repeat (5) step(4'b0000, 1'b1);
      codes("burst", 3, '{0, 1, 3, 0}, '{3, 0, 1, 0});

      rst = 1'b1;
      step(4'b0000, 1'b1);
      rst = 1'b0;
      clr();
      step(4'b1111, 1'b1);
      repeat (6) step(4'b0000, 1'b1);
      codes("all four", 4, '{0, 1, 2, 3}, '{0, 1, 2, 3});

      clr();
      step(4'b0011, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);
      repeat (4) step(4'b0000, 1'b1);
      codes("held pair", 2, '{0, 1, 0, 0}, '{0, 1, 0, 0});

      clr();
      step(4'b1001, 1'b1);
      repeat (4) step(4'b0000, 1'b1);
      codes("ends", 2, '{0, 3, 0, 0}, '{3, 0, 0, 0});

      clr();
      step(4'b0001, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);
      lit("bp hold", 2'd1, 2'd0, 4'b0000, 1'b0);
      step(4'b0010, 1'b0);
      lit("bp first", 2'd1, 2'd0, 4'b0010, 1'b0);
      step(4'b0010, 1'b0);
      lit("bp dup", 2'd1, 2'd0, 4'b0010, 1'b1);
      step(4'b0000, 1'b0);
      lit("bp after", 2'd1, 2'd0, 4'b0010, 1'b0);
      repeat (4) step(4'b0000, 1'b1);
      codes("bp drain", 2, '{0, 1, 0, 0}, '{0, 1, 0, 0});

      clr();
      step(4'b0001, 1'b0);
      step(4'b1010, 1'b0);
      lit("pre abort", 2'd1, 2'd0, 4'b1010, 1'b0);
      rst = 1'b1;
      step(4'b0000, 1'b1);
      rst = 1'b0;
      lit("abort", 2'd0, 2'd0, 4'b0000, 1'b0);
      for (int m = 0; m < 2; m++) chk("abort idle", m, 8'(idl[m]), 8'd1);
      clr();
      repeat (4) step(4'b0000, 1'b1);
      codes("after abort", 0, '{0, 0, 0, 0}, '{0, 0, 0, 0});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/encoder4x2_queue.md
# encoder4x2_queue

Registered 4-to-2 encoder with a sticky request queue and a valid/ready output handshake. It is the encoding counterpart of the 2-to-4 decoder. Four request lines set pending bits. The block emits each pending index, one at a time, as a 2-bit code {A,B} that can drive the decoder's A/B inputs directly. Fixed or round-robin priority resolves multiple pending requests. The block sits between request sources and a decoder-driven consumer.

## Interface
- RR_MODE, default 0: 0 = fixed priority, lowest index wins; 1 = round-robin, search starts at (last granted index + 1) mod 4.
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  synchronous active-high reset, sampled on rising clk.
- req  in  4  request lines; req[i]=1 in a cycle marks index i pending; level or pulse are both accepted.
- out_ready  in  1  consumer accepts the code this cycle.
- out_valid  out  1  {A,B} holds a valid code.
- A  out  1  code MSB.
- B  out  1  code LSB; code = {A,B} = granted index.
- pending  out  4  current pending register P.
- overflow  out  1  one-cycle pulse: a request was dropped because its bit was already pending.
- idle  out  1  P==0 and out_valid==0.

## Operation
- State: pending register P[3:0], output register {A,B}, out_valid, round-robin pointer last[1:0], overflow register.
- Controller states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- load condition: (EMPTY, or FULL with out_valid&&out_ready) and P!=0.
  - On load: select index k from the registered P, write {A,B}=k, set out_valid=1, set last=k, load_mask=1<<k.
- Selection:
  - RR_MODE=0: k = lowest set bit of P.
  - RR_MODE=1: k = first set bit scanning last+1, last+2, ... mod 4.
- FULL with out_valid&&out_ready and P==0 -> EMPTY; out_valid=0; {A,B} keep the last value.
- FULL with !out_ready: {A,B} and out_valid are held stable; no load occurs.
- P_next = (P & ~load_mask) | req. When req[k] and the load of k happen in the same cycle, the set wins and k stays pending.
- overflow_next = |(req & P & ~load_mask). This is a pure drop indicator; the duplicate request is merged, never queued twice.
- Reset: P=0, {A,B}=2'b00, out_valid=0, overflow=0, last=2'b11 (first round-robin search starts at 0), state EMPTY. Reset overrides req and out_ready in the same cycle and also aborts any code currently held.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency when EMPTY: req[i] sampled at edge N -> pending[i]=1 after N -> out_valid=1 with code i after N+1.
- Throughput: one code per cycle while out_ready=1 and P!=0; loads are back-to-back with no bubble.
- A code is consumed exactly on a cycle with out_valid&&out_ready. Each granted index is emitted exactly once per pending-set.
- overflow asserts for one cycle, on the edge after the offending req sample.

## Test plan
- Reset: rst=1 for 2 cycles with req=4'hF and out_ready=1 -> after rst drops, out_valid=0, {A,B}=00, pending=0, overflow=0, idle=1.
- Single request: req=4'b0100 for one cycle, out_ready=1 -> pending=0100 next cycle; then out_valid=1 with {A,B}=10 for exactly one cycle; then pending=0 and idle=1.
- Fixed priority burst (RR_MODE=0): req=4'b1011 for one cycle, out_ready=1 -> codes 00, 01, 11 on three consecutive cycles; then out_valid=0.
- Round-robin (RR_MODE=1): req=4'b1111 for one cycle -> codes 0,1,2,3. Then req=4'b0011 with out_ready=0 until both are pending, then out_ready=1 -> codes 0,1 (scan starts after last=3). Same stimulus with RR_MODE=0 and req=4'b1001 after a grant of 0 -> code 0 before 3.
- Backpressure/overflow: req=0001 with out_ready=0 -> code 00 is held valid and stable. Then req=0010 for 2 consecutive cycles -> overflow pulses one cycle and pending=0010. Then out_ready=1 -> code 00, then 01, each exactly once.
- Reset mid-operation: with pending=1010 and out_valid=1, assert rst for one cycle -> all outputs at reset values the next cycle, and no further codes appear without new req.
